// File: rtl/adc128s_pkg.sv
// Shared constants for the ADC128S-style SPI slave model.
package adc128s_pkg;

  localparam logic [4:0] FRAME_BITS = 5'd16;
  localparam logic [4:0] CNT_MAX    = 5'd31;

  localparam int CHNL_MSB = 13;
  localparam int CHNL_LSB = 11;

  localparam logic [2:0] LFT_CHNL_DEF  = 3'd0;
  localparam logic [2:0] RGHT_CHNL_DEF = 3'd4;
  localparam logic [2:0] BATT_CHNL_DEF = 3'd5;

endpackage

// File: rtl/adc_sync_edge.sv
// Two-flop synchronizer with a third flop for rise/fall detection.
module adc_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], d_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 3'b111;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign lvl  = sync_q[1];
  assign rise = sync_q[1] & ~sync_q[2];
  assign fall = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/adc128s_model.sv
// 8-channel 12-bit ADC128S-style SPI slave, one-frame pipelined result.
// Define ADC_PROTO_CHK_EN to flag and report malformed frames.
module adc128s_model
  import adc128s_pkg::*;
#(
  parameter logic [2:0] LFT_CHNL  = LFT_CHNL_DEF,
  parameter logic [2:0] RGHT_CHNL = RGHT_CHNL_DEF,
  parameter logic [2:0] BATT_CHNL = BATT_CHNL_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [11:0] batt_set,
  input  logic [11:0] lft_cell_set,
  input  logic [11:0] rght_cell_set
);

  logic ss_lvl, ss_rise, ss_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;

  logic [1:0]  mosi_q, mosi_d;
  logic [1:0]  vld_q, vld_d;
  logic        armed_q, armed_d;
  logic        frame_q, frame_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] tx_q, tx_d;
  logic [15:0] rx_q, rx_d;
  logic [2:0]  chnl_q, chnl_d;
  logic [11:0] result;

  adc_sync_edge u_ss (
    .clk   (clk),
    .rst_n (rst_n),
    .d_in  (SS_n),
    .lvl   (ss_lvl),
    .rise  (ss_rise),
    .fall  (ss_fall)
  );

  adc_sync_edge u_sclk (
    .clk   (clk),
    .rst_n (rst_n),
    .d_in  (SCLK),
    .lvl   (sclk_lvl),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  always_comb begin
    result = 12'h000;
    unique case (1'b1)
      (chnl_q == LFT_CHNL):  result = lft_cell_set;
      (chnl_q == RGHT_CHNL): result = rght_cell_set;
      (chnl_q == BATT_CHNL): result = batt_set;
      default:               result = 12'h000;
    endcase
  end

  // A frame may only start once an idle bus (SS_n and SCLK high) has
  // been seen through real synchronizer samples, not reset values.
  always_comb begin
    mosi_d  = {mosi_q[0], MOSI};
    vld_d   = {vld_q[0], 1'b1};
    armed_d = armed_q | (vld_q[1] & ss_lvl & sclk_lvl);
    frame_d = frame_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    chnl_d  = chnl_q;
    if (ss_fall && armed_q) begin
      frame_d = 1'b1;
      cnt_d   = 5'd0;
      tx_d    = {4'h0, result};
    end else if (frame_q) begin
      if (ss_rise) begin
        frame_d = 1'b0;
        if (cnt_q == FRAME_BITS) begin
          chnl_d = rx_q[CHNL_MSB:CHNL_LSB];
        end
      end else begin
        if (sclk_rise) begin
          rx_d = {rx_q[14:0], mosi_q[1]};
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        // first fall of a frame precedes any rise and must not shift
        if (sclk_fall && (cnt_q != 5'd0)) begin
          tx_d = {tx_q[14:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_q  <= 2'b11;
      vld_q   <= 2'b00;
      armed_q <= 1'b0;
      frame_q <= 1'b0;
      cnt_q   <= 5'd0;
      tx_q    <= 16'h0000;
      rx_q    <= 16'h0000;
      chnl_q  <= LFT_CHNL;
    end else begin
      mosi_q  <= mosi_d;
      vld_q   <= vld_d;
      armed_q <= armed_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      chnl_q  <= chnl_d;
    end
  end

  assign MISO = frame_q & tx_q[15];

`ifdef ADC_PROTO_CHK_EN
  logic proto_err;
  logic proto_err_d;
  logic err_end;

  assign err_end = frame_q & ss_rise & (cnt_q != FRAME_BITS);

  always_comb begin
    proto_err_d = proto_err | err_end;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proto_err <= 1'b0;
    end else begin
      proto_err <= proto_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && err_end) begin
      $error("adc128s_model: frame ended after %0d bits", cnt_q);
    end
  end
`endif

endmodule

// File: tb/tb_adc128s_model.sv
// Scoreboard bench for adc128s_model driving a bit-banged SPI master.
module tb_adc128s_model;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SS_n = 1'b1;
  logic        SCLK = 1'b1;
  logic        MOSI = 1'b0;
  logic        MISO;
  logic [11:0] batt_set = 12'h000;
  logic [11:0] lft_cell_set = 12'h000;
  logic [11:0] rght_cell_set = 12'h000;

  int total = 0;
  int bad = 0;
  logic [15:0] exp_q[$];
  logic [2:0]  mchnl = 3'd0;
  logic [15:0] rd;

  adc128s_model dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .SS_n          (SS_n),
    .SCLK          (SCLK),
    .MOSI          (MOSI),
    .MISO          (MISO),
    .batt_set      (batt_set),
    .lft_cell_set  (lft_cell_set),
    .rght_cell_set (rght_cell_set)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] mdl(input logic [2:0] c);
    case (c)
      3'd0:    return lft_cell_set;
      3'd4:    return rght_cell_set;
      3'd5:    return batt_set;
      default: return 12'h000;
    endcase
  endfunction

  task automatic spi_xfer(input logic [15:0] cmd, input int nbits,
                          input int chg_at, input int rst_at,
                          output logic [15:0] rx);
    rx = 16'h0000;
    SS_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b0;
      MOSI = (i < 16) ? cmd[15-i] : 1'b0;
      if (i == chg_at) rght_cell_set = 12'h2AB;
      if (i == rst_at) begin
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_miso", {15'h0, MISO}, 16'h0000);
        chk("rst_chnl", {13'h0, dut.chnl_q}, 16'h0000);
        rst_n = 1'b1;
      end
      repeat (8) @(negedge clk);
      rx = {rx[14:0], MISO};
      SCLK = 1'b1;
      repeat (8) @(negedge clk);
    end
    SS_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic frame(input logic [15:0] cmd, input int chg_at);
    logic [15:0] got;
    exp_q.push_back({4'h0, mdl(mchnl)});
    spi_xfer(cmd, 16, chg_at, -1, got);
    mchnl = cmd[13:11];
    if (exp_q.size() == 0) begin
      chk("sb_empty", got, 16'hxxxx);
    end else begin
      chk("rd", got, exp_q.pop_front());
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_miso0", {15'h0, MISO}, 16'h0000);
    chk("rst_chnl0", {13'h0, dut.chnl_q}, 16'h0000);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    lft_cell_set  = 12'h123;
    batt_set      = 12'h040;
    rght_cell_set = 12'h190;

    frame(16'h2800, -1);
    frame(16'h2000, -1);
    frame(16'h1000, 8);
    frame(16'h2000, -1);
    chk("chnl4", {13'h0, dut.chnl_q}, 16'h0004);

    spi_xfer(16'h2800, 9, -1, -1, rd);
    chk("abort_chnl", {13'h0, dut.chnl_q}, 16'h0004);
`ifdef ADC_PROTO_CHK_EN
    chk("proto_err", {15'h0, dut.proto_err}, 16'h0001);
`endif

    spi_xfer(16'h2800, 48, -1, -1, rd);
    chk("sat_chnl", {13'h0, dut.chnl_q}, 16'h0004);

    frame(16'h0000, -1);

    lft_cell_set = 12'h7FE;
    spi_xfer(16'h2800, 16, -1, 5, rd);
    mchnl = 3'd0;

    frame(16'h2800, -1);
    frame(16'h0000, -1);
    chk("chnl_end", {13'h0, dut.chnl_q}, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
